// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: byte-stream to serial CRC-8 engine sequencer.
// Accepts words over valid/ready with one word of reserve, shifts them out
// LSB-first on DATA/Active, then collects the serial CRC returned on CRC/Valid.
// Optional build macro CRC_FRAME_CNT_EN adds a 16-bit count of error-free frames.
module crc_frame_ctrl #(
  parameter int BYTE_W  = 8,
  parameter int CRC_W   = 8,
  parameter int TMO_CYC = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              crc_data_o,
  output logic              crc_active_o,
  input  logic              crc_serial_i,
  input  logic              crc_valid_i,
  output logic [CRC_W-1:0]  crc_result,
  output logic              result_valid,
  output logic              busy,
  output logic              err
`ifdef CRC_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int BC_W = $clog2(BYTE_W);
  localparam int CC_W = $clog2(CRC_W) + 1;
  localparam int TC_W = $clog2(TMO_CYC) + 1;

  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(BYTE_W - 1);
  localparam logic [CC_W-1:0] CAP_LAST = CC_W'(CRC_W - 1);
  localparam logic [TC_W-1:0] TMO_LAST = TC_W'(TMO_CYC - 1);
  localparam logic [TC_W-1:0] TMO_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, COLLECT, DRAIN} state_t;

  state_t            state;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] hold_reg;
  logic              hold_full;
  logic              hold_last;
  logic              last_seen;
  logic [BC_W-1:0]   bit_cnt;
  logic [CC_W-1:0]   cap_cnt;
  logic [TC_W-1:0]   tmo_cnt;
  logic              xfer;

  assign byte_ready = !hold_full && (state != COLLECT) && (state != DRAIN) && !last_seen;
  assign xfer       = byte_valid && byte_ready;
  assign busy       = (state != IDLE);

  // Frame sequencer: word intake, serialisation, CRC collection and drain.
  // crc_data_o is kept equal to shreg[0] by loading it with the next bit
  // alongside every shreg update, so the wire bit is registered yet aligned.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      hold_reg     <= '0;
      hold_full    <= 1'b0;
      hold_last    <= 1'b0;
      last_seen    <= 1'b0;
      bit_cnt      <= '0;
      cap_cnt      <= '0;
      tmo_cnt      <= '0;
      crc_data_o   <= 1'b0;
      crc_active_o <= 1'b0;
      crc_result   <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            shreg        <= byte_data;
            crc_data_o   <= byte_data[0];
            crc_active_o <= 1'b1;
            last_seen    <= byte_last;
            err          <= 1'b0;
            bit_cnt      <= '0;
            cap_cnt      <= '0;
            tmo_cnt      <= '0;
            crc_result   <= '0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt != BIT_LAST) begin
            shreg      <= shreg >> 1;
            crc_data_o <= shreg[1];
            bit_cnt    <= bit_cnt + BC_W'(1);
            if (xfer) begin
              hold_reg  <= byte_data;
              hold_last <= byte_last;
              hold_full <= 1'b1;
            end
          end else begin
            bit_cnt <= '0;
            if (last_seen) begin
              crc_active_o <= 1'b0;
              crc_data_o   <= 1'b0;
              last_seen    <= 1'b0;
              state        <= COLLECT;
            end else if (hold_full) begin
              shreg      <= hold_reg;
              crc_data_o <= hold_reg[0];
              last_seen  <= hold_last;
              hold_full  <= 1'b0;
            end else if (xfer) begin
              shreg      <= byte_data;
              crc_data_o <= byte_data[0];
              last_seen  <= byte_last;
            end else begin
              err          <= 1'b1;
              crc_active_o <= 1'b0;
              crc_data_o   <= 1'b0;
              state        <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (crc_valid_i) begin
            crc_result <= {crc_serial_i, crc_result[CRC_W-1:1]};
            cap_cnt    <= cap_cnt + CC_W'(1);
            if (cap_cnt == CAP_LAST) begin
              result_valid <= 1'b1;
              state        <= DRAIN;
            end
          end else if (cap_cnt == '0) begin
            if (tmo_cnt == TMO_LAST) begin
              err          <= 1'b1;
              result_valid <= 1'b1;
              state        <= DRAIN;
            end
            if (tmo_cnt != TMO_MAX) begin
              tmo_cnt <= tmo_cnt + TC_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!crc_valid_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRC_FRAME_CNT_EN
  // Count frames whose result strobe arrives with no error flagged.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (result_valid && !err) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Scoreboard bench for crc_frame_ctrl with a behavioural serial CRC-8 engine
// (poly 0x07, init 0, CRC returned LSB first) attached to the DATA/Active side.
module tb_crc_frame_ctrl;
  localparam int BYTE_W  = 8;
  localparam int CRC_W   = 8;
  localparam int TMO_CYC = 16;

  logic              CLK = 1'b0;
  logic              rst_n;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic              crc_data_o;
  logic              crc_active_o;
  logic              crc_serial_i;
  logic              crc_valid_i;
  logic [CRC_W-1:0]  crc_result;
  logic              result_valid;
  logic              busy;
  logic              err;
`ifdef CRC_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  always #5 CLK = ~CLK;

  crc_frame_ctrl #(.BYTE_W(BYTE_W), .CRC_W(CRC_W), .TMO_CYC(TMO_CYC)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_last(byte_last),
    .byte_ready(byte_ready), .crc_data_o(crc_data_o), .crc_active_o(crc_active_o),
    .crc_serial_i(crc_serial_i), .crc_valid_i(crc_valid_i),
    .crc_result(crc_result), .result_valid(result_valid), .busy(busy), .err(err)
`ifdef CRC_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  typedef struct {
    logic [7:0] crc;
    logic       err;
    bit         chk_crc;
    int         lat;
    bit         tmo;
  } exp_t;

  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         coll_cyc = 0;
  int         good_cnt = 0;
  bit         eng_mute = 1'b0;
  logic       prev_err = 1'b0;
  bit         exp_bits[$];
  int         run_len_q[$];
  exp_t       res_q[$];
  logic [7:0] fw[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: expected event missing or unexpected event t=%0t", name, $time);
  endtask

  // Reference CRC: remainder of (message * x^8) mod (x^8+x^2+x+1), message
  // taken word by word, each word LSB first.
  function automatic logic [7:0] ref_crc();
    bit         q[$];
    logic [7:0] r;
    logic       top;
    foreach (fw[i]) for (int b = 0; b < 8; b++) q.push_back(fw[i][b]);
    for (int b = 0; b < 8; b++) q.push_back(1'b0);
    r = 8'h00;
    foreach (q[i]) begin
      top = r[7];
      r   = {r[6:0], q[i]};
      if (top) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic       fb;
    logic [7:0] n;
    fb = c[7] ^ b;
    n  = {c[6:0], 1'b0};
    if (fb) n = n ^ 8'h07;
    return n;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Engine model: watches DATA/Active, returns the CRC on CRC/Valid.
  initial begin : engine
    bit         obs[$];
    logic [7:0] eng_crc;
    logic [7:0] eng_out;
    int         emit_left;
    int         emit_idx;
    int         exp_len;
    int         mism;
    bit         eb;
    eng_crc = '0; eng_out = '0; emit_left = 0; emit_idx = 0;
    crc_valid_i = 1'b0; crc_serial_i = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (!rst_n) begin
        obs.delete();
        emit_left = 0;
        crc_valid_i = 1'b0;
        crc_serial_i = 1'b0;
      end else begin
        if (crc_active_o) begin
          if (obs.size() == 0) eng_crc = 8'h00;
          obs.push_back(crc_data_o);
          eng_crc = crc_step(eng_crc, crc_data_o);
        end else if (obs.size() > 0) begin
          coll_cyc = cyc;
          chk("collect_data_low", crc_data_o, 1'b0);
          if (run_len_q.size() == 0) begin
            fail("run_unexpected");
          end else begin
            exp_len = run_len_q.pop_front();
            chk("run_len", obs.size(), exp_len);
            mism = 0;
            for (int i = 0; i < exp_len; i++) begin
              eb = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'b0;
              if (i >= obs.size() || obs[i] != eb) mism++;
            end
            chk("run_bits", mism, 0);
          end
          eng_out = eng_crc;
          if (!eng_mute) begin
            emit_idx  = 0;
            emit_left = CRC_W + $urandom_range(0, 3);
          end
          obs.delete();
        end
        if (emit_left > 0) begin
          crc_valid_i  = 1'b1;
          crc_serial_i = eng_out[emit_idx % 8];
          emit_idx++;
          emit_left--;
        end else begin
          crc_valid_i  = 1'b0;
          crc_serial_i = 1'b0;
        end
      end
    end
  end

  // Result monitor: pops the expected result whenever the strobe appears.
  initial begin : monitor
    exp_t rec;
    forever begin
      @(posedge CLK); #1;
      if (rst_n && result_valid) begin
        if (res_q.size() == 0) begin
          fail("result_unexpected");
        end else begin
          rec = res_q.pop_front();
          chk("res_err", err, rec.err);
          chk("res_latency", cyc - coll_cyc, rec.lat);
          if (rec.chk_crc) chk("res_crc", crc_result, rec.crc);
          if (!rec.err) good_cnt++;
          @(posedge CLK); #1;
          chk("strobe_one_cycle", result_valid, 1'b0);
          if (rec.tmo) chk("tmo_busy_fall", busy, 1'b0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    if (busy) fail("idle_wait");
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    byte_data = d; byte_last = l; byte_valid = 1'b1;
    while (!byte_ready && n < 200) begin tick(); n++; end
    if (!byte_ready) begin
      fail("ready_wait");
      byte_valid = 1'b0;
      return;
    end
    tick();
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic do_frame(input bit underrun, input bit mute, input int maxgap);
    exp_t e;
    int   g;
    wait_idle();
    chk("err_sticky", err, prev_err);
    run_len_q.push_back(8 * fw.size());
    foreach (fw[i]) for (int b = 0; b < 8; b++) exp_bits.push_back(fw[i][b]);
    e.crc = ref_crc(); e.err = underrun || mute; e.chk_crc = !mute;
    e.lat = mute ? TMO_CYC : CRC_W; e.tmo = mute;
    res_q.push_back(e);
    eng_mute = mute;
    for (int i = 0; i < fw.size(); i++) begin
      if (i > 0) begin
        g = $urandom_range(0, maxgap);
        repeat (g) tick();
      end
      send_word(fw[i], (i == fw.size() - 1) && !underrun);
      if (i == 0) chk("err_clear_on_accept", err, 1'b0);
    end
    wait_idle();
    eng_mute = 1'b0;
    prev_err = underrun || mute;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int nw;
    bit ur;
    byte_data = '0; byte_valid = 1'b0; byte_last = 1'b0; rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_byte_ready", byte_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_active", crc_active_o, 1'b0);
    chk("rst_data", crc_data_o, 1'b0);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_crc_result", crc_result, 8'h00);

    fw.delete(); fw.push_back(8'h00);
    do_frame(1'b0, 1'b0, 0);
    fw.delete(); fw.push_back(8'hA5); fw.push_back(8'h3C); fw.push_back(8'hFF);
    do_frame(1'b0, 1'b0, 0);
    fw.delete(); fw.push_back(8'h11);
    do_frame(1'b1, 1'b0, 0);
    fw.delete(); fw.push_back(8'($urandom)); fw.push_back(8'($urandom));
    do_frame(1'b0, 1'b0, 2);
    fw.delete(); fw.push_back(8'h6E);
    do_frame(1'b0, 1'b1, 0);

    // Reset during bit 4 of 0x5A
    wait_idle();
    send_word(8'h5A, 1'b1);
    repeat (4) tick();
    chk("pre_rst_active", crc_active_o, 1'b1);
    chk("pre_rst_bit4", crc_data_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_active", crc_active_o, 1'b0);
    chk("midrst_byte_ready", byte_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    prev_err = 1'b0;
    tick();
    fw.delete(); fw.push_back(8'hC3);
    do_frame(1'b0, 1'b0, 0);

    for (int f = 0; f < 24; f++) begin
      nw = $urandom_range(1, 4);
      ur = ($urandom_range(0, 5) == 0);
      fw.delete();
      for (int i = 0; i < nw; i++) fw.push_back(8'($urandom));
      do_frame(ur, 1'b0, 4);
    end

    n = 0;
    while ((res_q.size() != 0 || run_len_q.size() != 0) && n < 100) begin tick(); n++; end
    repeat (3) tick();
    chk("result_queue_drained", res_q.size(), 0);
    chk("run_queue_drained", run_len_q.size(), 0);
`ifdef CRC_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, 16'(good_cnt));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
